gray_updown_counter: RTL and testbench
======================================

# gray_updown_counter

Parametrised up/down Gray-code counter, the successor to the team's fixed 4-bit Gray counter. It keeps a binary count and a Gray-coded image of it, registered together, with enable, direction, parallel load and a wrap or saturate mode. The Gray output is intended for crossing to another clock domain, for example as a FIFO pointer. The binary output serves local arithmetic in the same domain.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal values are 2 to 32.
- SATURATE, 0, end-of-range behaviour: 0 wraps modulo 2^WIDTH, 1 holds at the range limit.
- INIT, 0, binary reset value; must be below 2^WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 counts up, 0 counts down; sampled only when en=1.
- load  input  1  parallel load strobe.
- load_gray  input  WIDTH  load value, Gray-coded.
- bin_count  output  WIDTH  registered binary count.
- gray_count  output  WIDTH  registered Gray count, always equal to bin_count ^ (bin_count >> 1).
- tc  output  1  registered terminal-count flag, high for one cycle.

## Operation
- State is the binary register `b`.
  - `gray_count` is a register written with bin2gray of the next value of `b`.
  - `gray_count` is never combinationally derived from an output register.
  - There is no one-cycle lag between `bin_count` and `gray_count`.
- Priority per clock edge: rst, then load, then en, then hold.
  - rst: `b`=INIT, `gray_count`=bin2gray(INIT), tc=0.
  - load (and not rst): `b`=gray2bin(load_gray), tc=0. `en` and `up` are ignored that cycle.
    - gray2bin: bit[WIDTH-1]=g[WIDTH-1]; bit[i]=bit[i+1]^g[i].
  - en=1, up=1:
    - `b` below MAX (2^WIDTH-1): `b`+1, tc=0.
    - `b`=MAX with SATURATE=0: `b`=0, tc=1.
    - `b`=MAX with SATURATE=1: `b` stays MAX, tc=1.
  - en=1, up=0:
    - `b` above 0: `b`-1, tc=0.
    - `b`=0 with SATURATE=0: `b`=MAX, tc=1.
    - `b`=0 with SATURATE=1: `b` stays 0, tc=1.
  - en=0: `b` and `gray_count` hold; tc=0.
- Arithmetic is unsigned WIDTH-bit. Only the range checks above produce a wrap; no carry or borrow leaves the block.
- Consecutive `gray_count` values differ in exactly one bit on every counting step, including wrap in either direction.
  - Load and reset are exempt from this rule.
  - A saturated hold changes zero bits.
- Direction may change on any cycle. The step uses `up` as sampled in that cycle.
- tc meaning: the step taken at the previous edge wrapped, or the previous edge attempted a step past the limit and held. tc is never high two cycles in a row unless consecutive steps each wrap or hold at the limit.

## Timing
- Single clock domain, no combinational input-to-output paths.
- Latency: inputs sampled at edge N appear on all three outputs after edge N.
- Reset: applies at the first edge with rst=1.
  - Outputs after that edge: `bin_count`=INIT, `gray_count`=bin2gray(INIT), tc=0.
  - Outputs before the first reset edge are undefined.
- Reset mid-count or mid-load takes effect that edge and discards the pending step or load.
- load with en=1 in the same cycle: load wins, and no step is applied that cycle.
- Throughput: one step per cycle, sustained indefinitely.

## Test plan
- WIDTH=4, SATURATE=0, INIT=0: reset, then en=1, up=1 for 16 cycles.
  - `gray_count` must run 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - tc=1 only after the 16th edge.
  - Check one-bit change on every step.
- WIDTH=4, SATURATE=0: from reset, en=1, up=0 for one cycle.
  - Required: `bin_count`=15, `gray_count`=1000, tc=1.
  - Next down step: `bin_count`=14, `gray_count`=1001, tc=0.
- load=1, load_gray=0110 with en=1, up=1 in the same cycle.
  - Required: `bin_count`=4, `gray_count`=0110, tc=0.
  - Next edge with en=1: `bin_count`=5, `gray_count`=0111.
- WIDTH=4, SATURATE=1: load 1000 (bin 15), then three up steps.
  - `bin_count` must stay 15 and `gray_count` stay 1000, with tc=1 after each step.
  - Then one down step: `bin_count`=14, tc=0.
- en toggled 1,0,0,1 while up=1, then up flipped to 0 mid-run.
  - The count must hold on en=0 cycles with tc=0.
  - The count must reverse on the first edge with up=0.
- Mid-run at `bin_count`=9, assert rst together with load=1.
  - Required: `bin_count`=INIT.
  - Repeat at WIDTH=8, INIT=200: `bin_count`=200, `gray_count`=8'b10101100.

Source files
------------

// File: rtl/gray_updown_counter_if.sv
// Control and count bus of the up/down Gray counter.
// The master drives the controls; the slave (counter) drives the counts.
interface gray_updown_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] bin_count;
    logic [WIDTH-1:0] gray_count;
    logic             tc;

    modport master (
        output en, up, load, load_gray,
        input  bin_count, gray_count, tc
    );

    modport slave (
        input  en, up, load, load_gray,
        output bin_count, gray_count, tc
    );
endinterface

// File: rtl/gray_updown_counter.sv
// Parametrised up/down counter keeping a binary count and its registered
// Gray image, with parallel Gray load and wrap or saturate at the range ends.
module gray_updown_counter #(
    parameter int          WIDTH    = 4,
    parameter bit          SATURATE = 1'b0,
    parameter logic [31:0] INIT     = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH-1:0] INIT_B = INIT[WIDTH-1:0];

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] g_q;
    logic             tc_q, tc_d;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] v;
        v[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            v[i] = v[i+1] ^ g[i];
        end
        return v;
    endfunction

    // NOTE: defaults first so every path assigns b_d and tc_d; no latch is inferred.
    always_comb begin
        b_d  = b_q;
        tc_d = 1'b0;
        if (bus.load) begin
            b_d = gray2bin(bus.load_gray);
        end else if (bus.en) begin
            if (bus.up) begin
                if (b_q == MAX) begin
                    tc_d = 1'b1;
                    b_d  = SATURATE ? MAX : '0;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end else begin
                if (b_q == '0) begin
                    tc_d = 1'b1;
                    b_d  = SATURATE ? '0 : MAX;
                end else begin
                    b_d = b_q - 1'b1;
                end
            end
        end
    end

    // Gray is registered from the next binary value so both outputs change
    // on the same edge and the Gray output is glitch-free for a CDC reader.
    // NOTE: non-blocking assignments keep all three registers updating in parallel.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q  <= INIT_B;
            g_q  <= bin2gray(INIT_B);
            tc_q <= 1'b0;
        end else begin
            b_q  <= b_d;
            g_q  <= bin2gray(b_d);
            tc_q <= tc_d;
        end
    end

    assign bus.bin_count  = b_q;
    assign bus.gray_count = g_q;
    assign bus.tc         = tc_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream,
// a reference model queues expectations and a monitor checks each edge.
module tb_gray_updown_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_updown_counter_if #(.WIDTH(4)) if0 ();
    gray_updown_counter_if #(.WIDTH(4)) if1 ();
    gray_updown_counter_if #(.WIDTH(8)) if2 ();

    gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .INIT(32'd0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1), .INIT(32'd0))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    gray_updown_counter #(.WIDTH(8), .SATURATE(1'b0), .INIT(32'd200))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    // kind: 0 = reset/load (no adjacency rule), 1 = counting step, 2 = hold
    typedef struct {
        logic [31:0] bin;
        logic [31:0] gray;
        logic        tc;
        int          kind;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int          cfg_w[3] = '{4, 4, 8};
    bit          cfg_s[3] = '{1'b0, 1'b1, 1'b0};
    int unsigned cfg_i[3] = '{0, 0, 200};

    int unsigned model_b[3];
    bit          armed = 1'b0;
    int unsigned prev_g[3];
    bit          have_prev[3] = '{1'b0, 1'b0, 1'b0};

    int compared   = 0;
    int mismatched = 0;

    function automatic int unsigned gray_of(int unsigned v);
        return v ^ (v >> 1);
    endfunction

    // Inverse Gray found by search over the whole range.
    function automatic int unsigned bin_of_gray(int unsigned g, int w);
        for (int unsigned v = 0; v < (32'd1 << w); v++) begin
            if (gray_of(v) == g) return v;
        end
        return 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, req);
        end
    endtask

    task automatic check_dut(int k, exp_t x, logic [31:0] b, logic [31:0] g, logic t);
        check($sformatf("dut%0d bin_count", k), b, x.bin);
        check($sformatf("dut%0d gray_count", k), g, x.gray);
        check($sformatf("dut%0d tc", k), 32'(t), 32'(x.tc));
        if (have_prev[k] && x.kind != 0)
            check($sformatf("dut%0d gray bits changed", k),
                  32'($countones(g ^ prev_g[k])), (x.kind == 1) ? 32'd1 : 32'd0);
        prev_g[k]    = g;
        have_prev[k] = 1'b1;
    endtask

    task automatic apply(bit r, bit ld, bit e, bit u, logic [7:0] lg);
        exp_t        x;
        int unsigned mx;
        int unsigned lgk;
        @(negedge clk);
        rst = r;
        if0.en = e; if0.up = u; if0.load = ld; if0.load_gray = lg[3:0];
        if1.en = e; if1.up = u; if1.load = ld; if1.load_gray = lg[3:0];
        if2.en = e; if2.up = u; if2.load = ld; if2.load_gray = lg;
        if (r) armed = 1'b1;
        if (!armed) return;
        for (int k = 0; k < 3; k++) begin
            mx     = (32'd1 << cfg_w[k]) - 1;
            lgk    = (cfg_w[k] == 8) ? 32'(lg) : 32'(lg[3:0]);
            x.tc   = 1'b0;
            x.kind = 0;
            if (r) begin
                model_b[k] = cfg_i[k];
            end else if (ld) begin
                model_b[k] = bin_of_gray(lgk, cfg_w[k]);
            end else if (!e) begin
                x.kind = 2;
            end else begin
                int unsigned limit = u ? mx : 0;
                if (model_b[k] == limit) begin
                    x.tc = 1'b1;
                    if (cfg_s[k]) x.kind = 2;
                    else begin
                        x.kind     = 1;
                        model_b[k] = u ? 0 : mx;
                    end
                end else begin
                    x.kind     = 1;
                    model_b[k] = u ? model_b[k] + 1 : model_b[k] - 1;
                end
            end
            x.bin  = model_b[k];
            x.gray = gray_of(model_b[k]);
            case (k)
                0:       q0.push_back(x);
                1:       q1.push_back(x);
                default: q2.push_back(x);
            endcase
        end
    endtask

    // Monitor: every edge after reset presents a result on all three DUTs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0)
                check_dut(0, q0.pop_front(), 32'(if0.bin_count), 32'(if0.gray_count), if0.tc);
            if (q1.size() > 0)
                check_dut(1, q1.pop_front(), 32'(if1.bin_count), 32'(if1.gray_count), if1.tc);
            if (q2.size() > 0)
                check_dut(2, q2.pop_front(), 32'(if2.bin_count), 32'(if2.gray_count), if2.tc);
        end
    end

    initial begin
        rst = 1'b0;
        if0.en = 1'b0; if0.up = 1'b0; if0.load = 1'b0; if0.load_gray = '0;
        if1.en = 1'b0; if1.up = 1'b0; if1.load = 1'b0; if1.load_gray = '0;
        if2.en = 1'b0; if2.up = 1'b0; if2.load = 1'b0; if2.load_gray = '0;

        // Full up sweep with wrap
        apply(1, 0, 0, 0, 8'h00);
        repeat (16) apply(0, 0, 1, 1, 8'h00);
        // Down wrap from reset, then one more down step
        apply(1, 0, 0, 0, 8'h00);
        apply(0, 0, 1, 0, 8'h00);
        apply(0, 0, 1, 0, 8'h00);
        // Load beats a simultaneous up step
        apply(0, 1, 1, 1, 8'h06);
        apply(0, 0, 1, 1, 8'h00);
        // Load Gray 1000, push past the top, then step down
        apply(0, 1, 0, 0, 8'h08);
        repeat (3) apply(0, 0, 1, 1, 8'h00);
        apply(0, 0, 1, 0, 8'h00);
        // Enable gaps, then a direction reversal mid-run
        apply(0, 0, 1, 1, 8'h00);
        apply(0, 0, 0, 1, 8'h00);
        apply(0, 0, 0, 1, 8'h00);
        apply(0, 0, 1, 1, 8'h00);
        apply(0, 0, 1, 0, 8'h00);
        apply(0, 0, 1, 0, 8'h00);
        // Reset together with load mid-run
        apply(1, 0, 0, 0, 8'h00);
        repeat (9) apply(0, 0, 1, 1, 8'h00);
        apply(1, 1, 1, 1, 8'h06);
        apply(0, 0, 1, 1, 8'h00);

        // Random traffic
        repeat (600) begin
            apply(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom),
                  8'($urandom));
        end
        apply(0, 0, 0, 0, 8'h00);

        @(posedge clk);
        #3;
        check("dut0 drain", 32'(q0.size()), 32'd0);
        check("dut1 drain", 32'(q1.size()), 32'd0);
        check("dut2 drain", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
